// File: rtl/mem_line_responder.sv
// Line-wide memory responder: accepts line read/write requests, services each after a fixed latency
// and returns read lines through a small response FIFO. MEM_LINE_RESPONDER_STATS_EN adds counters.
module mem_line_responder #(
  parameter int unsigned LINE_AW   = 10,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_cmd,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_data,
  input  logic         req_en,
  output logic         req_rdy,
  output logic [127:0] rsp_data,
  output logic         rsp_en,
`ifdef MEM_LINE_RESPONDER_STATS_EN
  output logic [31:0]  stat_reads,
  output logic [31:0]  stat_writes,
`endif
  input  logic         rsp_rdy
);

  localparam int unsigned PtrW = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 cmd_q, cmd_d;
  logic [LINE_AW-1:0]   idx_q, idx_d;
  logic [127:0]         data_q, data_d;
  logic                 push, pop, mem_we;

  logic [127:0]         mem_q  [2**LINE_AW];
  logic [127:0]         fifo_q [RSP_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]        count_q, count_d;

  // Offset bits and bits above the line index alias onto the same line.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:LINE_AW+2], req_addr[1:0]};

  assign req_rdy  = (state_q == StIdle) && (count_q < (PtrW+1)'(RSP_DEPTH));
  assign rsp_en   = (count_q != '0);
  assign rsp_data = rsp_en ? fifo_q[rd_ptr_q] : '0;
  assign pop      = rsp_en && rsp_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    data_d  = data_q;
    push    = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_en && req_rdy) begin
          cmd_d   = req_cmd;
          idx_d   = req_addr[LINE_AW+1:2];
          data_d  = req_data;
          cnt_d   = 8'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 8'd0) state_d = StAccess;
        else               cnt_d   = cnt_q - 8'd1;
      end
      StAccess: begin
        push    = cmd_q;
        mem_we  = ~cmd_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cmd_q    <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Array and FIFO storage carry no reset; FIFO validity comes from count_q.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= data_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_q[idx_q];
  end

`ifdef MEM_LINE_RESPONDER_STATS_EN
  logic [31:0] stat_reads_q, stat_writes_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else if (state_q == StAccess) begin
      if (cmd_q) stat_reads_q  <= stat_reads_q + 32'd1;
      else       stat_writes_q <= stat_writes_q + 32'd1;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif

endmodule
